// File: rtl/pid_pkg.sv
// Shared constants and types for the PID controller slice.
// Default widths live here so the parent's register map and the datapath agree.
package pid_pkg;

    localparam int PID_DATA_W = 16;
    localparam int PID_GAIN_W = 16;
    localparam int PID_INT_W  = 24;

    // Gain set as held in the parent's register map.
    typedef struct packed {
        logic signed [PID_GAIN_W-1:0] kp;
        logic signed [PID_GAIN_W-1:0] ki;
        logic signed [PID_GAIN_W-1:0] kd;
    } pid_gains_t;

endpackage

// File: rtl/pid_controller_if.sv
// Sample/control bus between the error front end, the PID core and the actuator side.
//
// Handshake: valid-only, no ready. A sample is transferred on every rising clk
// edge where in_valid is high; the core always accepts it. out_valid is a
// one-cycle pulse per produced control word; the consumer must take it then.
// Gains and limits are quasi-static configuration, not part of the handshake.
interface pid_controller_if
    import pid_pkg::*;
#(
    parameter int DATA_W = PID_DATA_W,
    parameter int GAIN_W = PID_GAIN_W
) ();

    logic                     in_valid;
    logic signed [DATA_W-1:0] error;
    logic                     clear;
    logic signed [GAIN_W-1:0] kp;
    logic signed [GAIN_W-1:0] ki;
    logic signed [GAIN_W-1:0] kd;
    logic signed [DATA_W-1:0] out_min;
    logic signed [DATA_W-1:0] out_max;
    logic                     out_valid;
    logic signed [DATA_W-1:0] control;
    logic                     sat_hi;
    logic                     sat_lo;

    // Upstream side: supplies samples and configuration, observes the control word.
    modport master (
        output in_valid, error, clear, kp, ki, kd, out_min, out_max,
        input  out_valid, control, sat_hi, sat_lo
    );

    // PID core side.
    modport slave (
        input  in_valid, error, clear, kp, ki, kd, out_min, out_max,
        output out_valid, control, sat_hi, sat_lo
    );

endinterface

// File: rtl/pid_sat_clamp.sv
// Combinational clamp of a wide signed value into [lo, hi] of a narrower width.
// With constant lo/hi at the type extremes it doubles as a saturating adder's
// final stage. If lo > hi the configuration is inconsistent and lo wins.
module pid_sat_clamp #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  value,
    input  logic signed [OUT_W-1:0] lo,
    input  logic signed [OUT_W-1:0] hi,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    localparam int EXT_W = IN_W - OUT_W;

    logic signed [IN_W-1:0] lo_ext;
    logic signed [IN_W-1:0] hi_ext;

    assign lo_ext = {{EXT_W{lo[OUT_W-1]}}, lo};
    assign hi_ext = {{EXT_W{hi[OUT_W-1]}}, hi};

    // Select pass-through, upper bound or lower bound; inverted limits force the lower bound.
    always_comb begin
        y      = value[OUT_W-1:0];
        sat_hi = 1'b0;
        sat_lo = 1'b0;
        if (lo > hi) begin
            y      = lo;
            sat_lo = 1'b1;
        end else if (value > hi_ext) begin
            y      = hi;
            sat_hi = 1'b1;
        end else if (value < lo_ext) begin
            y      = lo;
            sat_lo = 1'b1;
        end
    end

endmodule

// File: rtl/pid_controller.sv
// Three-stage pipelined PID controller with saturating, anti-windup integrator
// and programmable output clamp.
//   S1: register error, derivative difference, update integrator
//   S2: full-precision kp/ki/kd products
//   S3: sum, arithmetic shift by FRAC_W (floor), clamp, register outputs
// Build option: define PID_DERIV_EN to compile in the derivative path
// (e_prev, de1, kd multiplier). Without it d is zero and kd is ignored.
module pid_controller
    import pid_pkg::*;
#(
    parameter int DATA_W = PID_DATA_W,
    parameter int GAIN_W = PID_GAIN_W,
    parameter int INT_W  = PID_INT_W,
    parameter int FRAC_W = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    pid_controller_if.slave  bus
);

    localparam int E_W   = DATA_W + 1;      // error / difference width
    localparam int P_W   = GAIN_W + E_W;    // p and d product width
    localparam int I_W   = GAIN_W + INT_W;  // i product width
    localparam int SUM_W = I_W + 3;         // three products cannot overflow this

    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    // Output registers, also the anti-windup flags.
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] control_q;
    logic                     sat_hi_q;
    logic                     sat_lo_q;

    // S1 state
    logic                     v1;
    logic signed [E_W-1:0]    e1;
    logic signed [INT_W-1:0]  integ;

    // S2 state
    logic                     v2;
    logic signed [P_W-1:0]    p;
    logic signed [I_W-1:0]    i;
    logic signed [P_W-1:0]    d;

    // Integrator saturating add and anti-windup hold
    logic signed [INT_W:0]    integ_sum;
    logic signed [INT_W-1:0]  integ_next;
    logic                     unused_integ_hi;
    logic                     unused_integ_lo;
    logic                     err_pos;
    logic                     err_neg;
    logic                     hold;

    assign integ_sum = {integ[INT_W-1], integ}
                     + {{(INT_W+1-DATA_W){bus.error[DATA_W-1]}}, bus.error};

    pid_sat_clamp #(
        .IN_W  (INT_W + 1),
        .OUT_W (INT_W)
    ) u_integ_sat (
        .value  (integ_sum),
        .lo     (INT_MIN),
        .hi     (INT_MAX),
        .y      (integ_next),
        .sat_hi (unused_integ_hi),
        .sat_lo (unused_integ_lo)
    );

    assign err_neg = bus.error[DATA_W-1];
    assign err_pos = !err_neg && (bus.error != '0);
    // Flags come from the most recent output, so up to two in-flight samples still integrate.
    assign hold    = (sat_hi_q && err_pos) || (sat_lo_q && err_neg);

    // S1: capture error and step the integrator; clear zeroes it and drops the sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            e1    <= '0;
            integ <= '0;
        end else if (bus.clear) begin
            v1    <= 1'b0;
            integ <= '0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                e1 <= {bus.error[DATA_W-1], bus.error};
                if (!hold) begin
                    integ <= integ_next;
                end
            end
        end
    end

`ifdef PID_DERIV_EN
    logic signed [DATA_W-1:0] e_prev;
    logic signed [E_W-1:0]    de1;
    logic signed [P_W-1:0]    kd_x;
    logic signed [P_W-1:0]    de_x;

    assign kd_x = {{E_W{bus.kd[GAIN_W-1]}}, bus.kd};
    assign de_x = {{GAIN_W{de1[E_W-1]}}, de1};

    // S1 derivative history: difference against the previous accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_prev <= '0;
            de1    <= '0;
        end else if (bus.clear) begin
            e_prev <= '0;
        end else if (bus.in_valid) begin
            de1    <= {bus.error[DATA_W-1], bus.error} - {e_prev[DATA_W-1], e_prev};
            e_prev <= bus.error;
        end
    end

    // S2 derivative product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d <= '0;
        end else if (!bus.clear && v1) begin
            d <= kd_x * de_x;
        end
    end
`else
    logic unused_kd;

    assign unused_kd = ^bus.kd;
    assign d         = '0;
`endif

    logic signed [P_W-1:0] kp_x;
    logic signed [P_W-1:0] e1_x;
    logic signed [I_W-1:0] ki_x;
    logic signed [I_W-1:0] integ_x;

    // Operands widened to the product width so the truncated product is exact.
    assign kp_x    = {{E_W{bus.kp[GAIN_W-1]}}, bus.kp};
    assign e1_x    = {{GAIN_W{e1[E_W-1]}}, e1};
    assign ki_x    = {{INT_W{bus.ki[GAIN_W-1]}}, bus.ki};
    assign integ_x = {{GAIN_W{integ[INT_W-1]}}, integ};

    // S2: proportional and integral products; integ already holds this sample's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2 <= 1'b0;
            p  <= '0;
            i  <= '0;
        end else if (bus.clear) begin
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                p <= kp_x * e1_x;
                i <= ki_x * integ_x;
            end
        end
    end

    // S3 combinational: widen, add, floor-shift, clamp.
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  y_shift;
    logic signed [DATA_W-1:0] clamp_y;
    logic                     clamp_hi;
    logic                     clamp_lo;

    assign sum = {{(SUM_W-P_W){p[P_W-1]}}, p}
               + {{(SUM_W-I_W){i[I_W-1]}}, i}
               + {{(SUM_W-P_W){d[P_W-1]}}, d};
    assign y_shift = sum >>> FRAC_W;

    pid_sat_clamp #(
        .IN_W  (SUM_W),
        .OUT_W (DATA_W)
    ) u_out_clamp (
        .value  (y_shift),
        .lo     (bus.out_min),
        .hi     (bus.out_max),
        .y      (clamp_y),
        .sat_hi (clamp_hi),
        .sat_lo (clamp_lo)
    );

    // S3: register control word and flags; they hold when no sample arrives or on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            control_q   <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v2;
            if (v2) begin
                control_q <= clamp_y;
                sat_hi_q  <= clamp_hi;
                sat_lo_q  <= clamp_lo;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.control   = control_q;
    assign bus.sat_hi    = sat_hi_q;
    assign bus.sat_lo    = sat_lo_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed bench for pid_controller: PI step, clear, clamp/anti-windup,
// inverted limits, derivative, async reset and fractional floor rounding.
module tb_pid_controller;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef PID_DERIV_EN
    localparam int D_EXP = 20;
`else
    localparam int D_EXP = 0;
`endif

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    pid_controller_if #(.DATA_W(16), .GAIN_W(16)) b0 ();
    pid_controller_if #(.DATA_W(16), .GAIN_W(16)) b8 ();

    pid_controller #(.DATA_W(16), .GAIN_W(16), .INT_W(24), .FRAC_W(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0.slave)
    );

    pid_controller #(.DATA_W(16), .GAIN_W(16), .INT_W(24), .FRAC_W(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive one cycle of the FRAC_W=0 instance at the falling edge.
    task automatic send(input logic v, input logic signed [15:0] e);
        @(negedge clk);
        b0.in_valid = v;
        b0.error    = e;
        b0.clear    = 1'b0;
    endtask

    task automatic send_clear(input logic v, input logic signed [15:0] e);
        @(negedge clk);
        b0.in_valid = v;
        b0.error    = e;
        b0.clear    = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        b0.in_valid = 1'b0; b0.error = '0; b0.clear = 1'b0;
        b0.kp = 16'sd10; b0.ki = 16'sd5; b0.kd = 16'sd0;
        b0.out_min = -16'sd1000; b0.out_max = 16'sd1000;
        b8.in_valid = 1'b0; b8.error = '0; b8.clear = 1'b0;
        b8.kp = 16'sd384; b8.ki = 16'sd0; b8.kd = 16'sd0;
        b8.out_min = -16'sd1000; b8.out_max = 16'sd1000;

        // Reset values
        #12;
        check("rst_control",   b0.control,   0);
        check("rst_out_valid", b0.out_valid, 0);
        check("rst_sat_hi",    b0.sat_hi,    0);
        check("rst_sat_lo",    b0.sat_lo,    0);
        check("rst_control8",  b8.control,   0);
        @(negedge clk);
        reset_n = 1'b1;
        send(0, 0);
        send(0, 0);

        // PI step: 10*1 + 5*integ with integ 1,2,3
        send(1, 1); send(1, 1); send(1, 1);
        send(0, 0); check("pi_ctl0", b0.control, 15); check("pi_v0", b0.out_valid, 1);
        send(0, 0); check("pi_ctl1", b0.control, 20); check("pi_v1", b0.out_valid, 1);
        send(0, 0); check("pi_ctl2", b0.control, 25); check("pi_v2", b0.out_valid, 1);
        send(0, 0); check("pi_idle_v", b0.out_valid, 0); check("pi_hold", b0.control, 25);
        check("pi_sat_hi", b0.sat_hi, 0);

        // Clear with three samples in flight (third one arrives with clear)
        send(1, 1); send(1, 1); send_clear(1, 1);
        send(0, 0); check("clr_v0", b0.out_valid, 0); check("clr_hold", b0.control, 25);
        send(0, 0); check("clr_v1", b0.out_valid, 0);
        send(0, 0); check("clr_v2", b0.out_valid, 0);
        send(1, 1); send(0, 0); send(0, 0);
        send(0, 0); check("clr_next", b0.control, 15); check("clr_next_v", b0.out_valid, 1);

        // Clamp at out_max=100 with anti-windup: integ stops at 60
        send_clear(0, 0);
        b0.ki = 16'sd1; b0.out_max = 16'sd100;
        send(1, 20); send(1, 20); send(1, 20);
        send(1, 20); check("aw_clamp", b0.control, 100); check("aw_sat_hi", b0.sat_hi, 1);
        check("aw_sat_lo", b0.sat_lo, 0);
        send(1, 20); send(1, 20); send(1, -20);
        send(0, 0); send(0, 0);
        send(0, 0); check("aw_unwind", b0.control, -160); check("aw_unwind_hi", b0.sat_hi, 0);

        // Inverted limits: lower bound wins
        b0.out_min = 16'sd200; b0.out_max = 16'sd100;
        send(1, 0); send(0, 0); send(0, 0);
        send(0, 0); check("inv_ctl", b0.control, 200); check("inv_sat_lo", b0.sat_lo, 1);
        check("inv_sat_hi", b0.sat_hi, 0);
        b0.out_min = -16'sd50; b0.out_max = 16'sd1000;
        // Negative error while sat_lo: integrator holds at 40
        send(1, -20); send(0, 0); send(0, 0);
        send(0, 0); check("lo_clamp", b0.control, -50); check("lo_sat_lo", b0.sat_lo, 1);
        b0.out_min = -16'sd1000;
        send(1, 0); send(0, 0); send(0, 0);
        send(0, 0); check("lo_hold_integ", b0.control, 40); check("lo_flag_clr", b0.sat_lo, 0);

        // Derivative: kd=2, errors 0,10,10
        b0.kp = 16'sd0; b0.ki = 16'sd0; b0.kd = 16'sd2;
        send(1, 0); send(1, 10); send(1, 10);
        send(0, 0); check("der0", b0.control, 0);
        send(0, 0); check("der1", b0.control, D_EXP);
        send(0, 0); check("der2", b0.control, 0);

        // Async reset with the pipeline full
        b0.kp = 16'sd10; b0.ki = 16'sd5; b0.kd = 16'sd0; b0.out_max = 16'sd100;
        send(1, 1); send(1, 1); send(1, 1);
        send(1, 1); check("pre_rst_ctl", b0.control, 100); check("pre_rst_hi", b0.sat_hi, 1);
        #2;
        reset_n = 1'b0;
        b0.in_valid = 1'b0;
        #1;
        check("arst_control", b0.control, 0);
        check("arst_valid",   b0.out_valid, 0);
        check("arst_sat_hi",  b0.sat_hi, 0);
        b0.out_max = 16'sd1000;
        send(0, 0);
        reset_n = 1'b1;
        send(0, 0); check("post_rst_v0", b0.out_valid, 0);
        send(0, 0); check("post_rst_v1", b0.out_valid, 0);
        send(1, 1);
        send(0, 0); check("lat_v1", b0.out_valid, 0);
        send(0, 0); check("lat_v2", b0.out_valid, 0);
        send(0, 0); check("lat_v3", b0.out_valid, 1); check("lat_ctl", b0.control, 15);

        // Fractional gain 1.5 (FRAC_W=8): floor rounding
        @(negedge clk); b8.in_valid = 1'b1; b8.error = -16'sd3;
        @(negedge clk); b8.error = 16'sd3;
        @(negedge clk); b8.in_valid = 1'b0; b8.error = '0;
        @(negedge clk); check("frac_neg", b8.control, -5); check("frac_v", b8.out_valid, 1);
        @(negedge clk); check("frac_pos", b8.control, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
